rr_arbiter4: RTL



---
 rtl/rr_arbiter4.sv | 100 ++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: grant held until the owner releases, one idle cycle between grants.
// Optional ARB_TIMEOUT_EN revokes a grant held for MAX_HOLD cycles and pulses timeout.
module rr_arbiter4 #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic             sel_found;

  // Rotating search from ptr; IDX_W-bit wrap gives the modulo-N step.
  always_comb begin
    sel       = '0;
    cand      = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!sel_found && req[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  logic [CNT_W-1:0] hold_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sel_found) begin
            state       <= GRANT;
            grant       <= N'(1) << sel;
            grant_idx   <= sel;
            grant_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
          end
        end
        GRANT: begin
          if (!req[grant_idx]) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          // Counter is one behind the visible hold length, so the grant lasts exactly MAX_HOLD cycles.
          else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 1'b1;
            timeout     <= 1'b1;
          end else begin
            hold_cnt    <= hold_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
